// File: rtl/addsub_pipe_32_if.sv
// Handshake and data bundle for the two-stage add/subtract unit.
// The slave view belongs to the unit; the master view belongs to whoever feeds and drains it.
interface addsub_pipe_32_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, negative
  );
endinterface

// File: rtl/addsub_pipe_32.sv
// Two-stage pipelined add/subtract: stage 1 resolves the low half and hands its carry
// to stage 2, which resolves the high half and the flags. Each half is 4-bit lookahead slices.
module addsub_pipe_32 #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  addsub_pipe_32_if.slave   bus
);
  localparam int HALF   = WIDTH / 2;
  localparam int NSLICE = HALF / 4;

  // Half-width adder: each 4-bit slice reports block propagate/generate, and the group
  // unit forms every slice carry-in directly from those and cin, so slices never chain.
  function automatic logic [HALF:0] cla_add(input logic [HALF-1:0] x,
                                            input logic [HALF-1:0] y,
                                            input logic            cin);
    logic [HALF-1:0]   p;
    logic [HALF-1:0]   g;
    logic [HALF-1:0]   s;
    logic [NSLICE-1:0] bp;
    logic [NSLICE-1:0] bg;
    logic [NSLICE:0]   c;
    logic              prod;
    logic              cb;
    // NOTE: every local gets a value before any conditional use, so no state is implied.
    p    = x ^ y;
    g    = x & y;
    s    = '0;
    bp   = '0;
    bg   = '0;
    c    = '0;
    prod = 1'b0;
    cb   = 1'b0;

    for (int k = 0; k < NSLICE; k++) begin
      bp[k] = &p[4*k +: 4];
      for (int j = 0; j < 4; j++) begin
        bg[k] = g[4*k+j] | (p[4*k+j] & bg[k]);
      end
    end

    c[0] = cin;
    for (int k = 1; k <= NSLICE; k++) begin
      prod = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        c[k] = c[k] | (prod & bg[j]);
        prod = prod & bp[j];
      end
      c[k] = c[k] | (prod & cin);
    end

    for (int k = 0; k < NSLICE; k++) begin
      cb = c[k];
      for (int j = 0; j < 4; j++) begin
        s[4*k+j] = p[4*k+j] ^ cb;
        cb       = g[4*k+j] | (p[4*k+j] & cb);
      end
    end
    return {c[NSLICE], s};
  endfunction

  logic             s1_valid;
  logic [HALF-1:0]  s1_lo;
  logic             s1_c_half;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_b_hi;

  logic [WIDTH-1:0] b_eff;
  logic [HALF:0]    lo_sum;
  logic [HALF:0]    hi_sum;
  logic [WIDTH-1:0] res_next;
  logic             s2_adv;
  logic             in_ready;
  logic             in_xfer;

  assign b_eff    = bus.op_sub ? ~bus.b : bus.b;
  assign lo_sum   = cla_add(bus.a[HALF-1:0], b_eff[HALF-1:0], bus.op_sub);
  assign hi_sum   = cla_add(s1_a_hi, s1_b_hi, s1_c_half);
  assign res_next = {hi_sum[HALF-1:0], s1_lo};

  assign s2_adv       = s1_valid && (!bus.out_valid || bus.out_ready);
  assign in_ready     = !s1_valid || s2_adv;
  assign in_xfer      = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_lo     <= lo_sum[HALF-1:0];
      s1_c_half <= lo_sum[HALF];
      s1_a_hi   <= bus.a[WIDTH-1:HALF];
      s1_b_hi   <= b_eff[WIDTH-1:HALF];
    end
  end

  // Output register doubles as the stall buffer: it only changes on a stage-2 advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
      bus.negative  <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= 1'b1;
      bus.result    <= res_next;
      bus.carry     <= hi_sum[HALF];
      bus.overflow  <= (s1_a_hi[HALF-1] == s1_b_hi[HALF-1]) &&
                       (res_next[WIDTH-1] != s1_a_hi[HALF-1]);
      bus.zero      <= ~|res_next;
      bus.negative  <= res_next[WIDTH-1];
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_addsub_pipe_32.sv
// Self-checking bench for addsub_pipe_32: directed corner cases, a random stream,
// a back-pressure episode and an asynchronous reset, all scored against a signed/unsigned model.
module tb_addsub_pipe_32;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_pipe_32_if #(.WIDTH(W)) bus ();

  addsub_pipe_32 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
  } res_t;

  res_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;

  // Reference: true-width integer arithmetic, wrapped afterwards.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t              r;
    longint unsigned   ua = a;
    longint unsigned   ub = b;
    longint            sa = $signed(a);
    longint            sb = $signed(b);
    longint            sr;
    if (!sub) begin
      r.result = a + b;
      r.carry  = ((ua + ub) >> W) != 0;
      sr       = sa + sb;
    end else begin
      r.result = a - b;
      r.carry  = (ua >= ub);
      sr       = sa - sb;
    end
    r.overflow = (sr != longint'($signed(r.result)));
    r.zero     = (r.result == '0);
    r.negative = r.result[W-1];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven; scores what the next
  // rising edge will transfer, then advances to the following falling edge.
  task automatic step();
    res_t e;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      check("output_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.result));
        check("flags", {60'd0, bus.carry, bus.overflow, bus.zero, bus.negative},
              {60'd0, e.carry, e.overflow, e.zero, e.negative});
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      n_in++;
      exp_q.push_back(model(bus.a, bus.b, bus.op_sub));
    end
    @(negedge clk);
  endtask

  task automatic expect_ov(input string tag, input logic v);
    #1;
    check(tag, 64'(bus.out_valid), 64'(v));
  endtask

  // One isolated operation with its latency and the hand-computed answer.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    step();
    bus.in_valid = 1'b0;
    expect_ov({tag, "_lat1"}, 1'b0);
    step();
    expect_ov({tag, "_lat2"}, 1'b1);
    check({tag, "_res"}, 64'(bus.result), 64'(exp_res));
    check({tag, "_flags"}, 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'(exp_flags));
    step();
  endtask

  logic [W-1:0] sa_op[3];
  logic [W-1:0] sb_op[3];
  logic         ss_op[3];

  initial begin
    int base_in;
    int base_out;
    int idx;

    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // Directed corner cases; flags are {carry, overflow, zero, negative}.
    run_one("add_5_3",  32'd5,          32'd3,          1'b0, 32'h0000_0008, 4'b0000);
    run_one("sub_0_1",  32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF, 4'b0001);
    run_one("add_ovf",  32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000, 4'b0101);
    run_one("add_half", 32'h0000_FFFF,  32'd1,          1'b0, 32'h0001_0000, 4'b0000);
    run_one("sub_zero", 32'h1234_ABCD,  32'h1234_ABCD,  1'b1, 32'h0000_0000, 4'b1010);

    // Back-to-back random stream at full throughput.
    base_out = n_out;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i < 8);
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'($urandom_range(0, 1));
      if (i < 8) begin
        #1;
        check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      end
      if (i >= 2) begin
        #1;
        check("stream_out_valid", 64'(bus.out_valid), 64'd1);
      end
      step();
    end
    expect_ov("stream_drained", 1'b0);
    check("stream_count", 64'(n_out - base_out), 64'd8);

    // Back-pressure: consumer stalls for 5 cycles while 3 operations are offered.
    for (int i = 0; i < 3; i++) begin
      sa_op[i] = $urandom;
      sb_op[i] = $urandom;
      ss_op[i] = 1'($urandom_range(0, 1));
    end
    base_in       = n_in;
    base_out      = n_out;
    bus.out_ready = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc == 5) bus.out_ready = 1'b1;
      idx          = n_in - base_in;
      bus.in_valid = (idx < 3);
      bus.a        = sa_op[idx % 3];
      bus.b        = sb_op[idx % 3];
      bus.op_sub   = ss_op[idx % 3];
      if (cyc >= 2 && cyc < 5) begin
        #1;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_accepted", 64'(n_in - base_in), 64'd2);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_hold_result", 64'(bus.result), 64'(exp_q[0].result));
        check("stall_hold_flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}),
              64'({exp_q[0].carry, exp_q[0].overflow, exp_q[0].zero, exp_q[0].negative}));
      end
      step();
    end
    bus.in_valid = 1'b0;
    check("stall_in_count", 64'(n_in - base_in), 64'd3);
    check("stall_out_count", 64'(n_out - base_out), 64'd3);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with two operations in flight.
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'b0;
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_flags", 64'({bus.carry, bus.overflow, bus.zero, bus.negative}), 64'd0);
    check("arst_result", 64'(bus.result), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
    check("arst_hold_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_one("post_rst", 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 4'b0001);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
